// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command stream, ALU operand/result and result stream bundle
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_r;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, alu_r, out_ready,
    output in_ready, alu_op, alu_a, alu_b, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, alu_r, out_ready,
    input  in_ready, alu_op, alu_a, alu_b, out_valid, out_data
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - header/a/b word sequencer feeding a combinational add/sub ALU
module alu_cmd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_sequencer_if.slave bus,
  output logic [COUNT_W-1:0] op_count,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_GET_A  = 3'd1,
    S_GET_B  = 3'd2,
    S_EXEC   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             in_ready;
  logic             out_valid;
  logic             in_fire;
  logic             out_fire;
  logic [1:0]       alu_op_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] acc;

  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_HDR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR:    if (in_fire) state_nxt = bus.in_data[2] ? S_GET_B : S_GET_A;
      S_GET_A:  if (in_fire) state_nxt = S_GET_B;
      S_GET_B:  if (in_fire) state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_RESULT;
      S_RESULT: if (out_fire) state_nxt = S_HDR;
      default:  state_nxt = S_HDR;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_HDR: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_GET_A:  in_ready  = 1'b1;
      S_GET_B:  in_ready  = 1'b1;
      S_RESULT: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Chained headers pull operand a from the last result on the header edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      out_data_q <= '0;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      if (in_fire && state == S_HDR) begin
        alu_op_q <= bus.in_data[1:0];
        if (bus.in_data[2]) alu_a_q <= acc;
      end
      if (in_fire && state == S_GET_A) alu_a_q <= bus.in_data;
      if (in_fire && state == S_GET_B) alu_b_q <= bus.in_data;
      if (state == S_EXEC) begin
        out_data_q <= bus.alu_r;
        acc        <= bus.alu_r;
      end
      if (out_fire) op_count <= op_count + COUNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - randomized bench for alu_cmd_sequencer against a command-level model
module tb_alu_cmd_sequencer;
  localparam int WIDTH = 16;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] op_count;
  logic          busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_acc    = '0;
  int          m_count  = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .COUNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .op_count (op_count),
    .busy     (busy)
  );

  // Stand-in for add_sub_logic: add, subtract, xor, unsigned greater-than.
  function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return (a > b) ? 16'd1 : 16'd0;
    endcase
  endfunction

  assign bus.alu_r = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] d);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input bit chain, input logic [15:0] a,
                         input logic [15:0] b, input int stall, input int gap);
    logic [15:0] ea;
    logic [15:0] er;
    logic [15:0] hdr;
    ea  = chain ? m_acc : a;
    er  = alu_fn(op, ea, b);
    hdr = {13'($urandom), chain, op};
    idle(gap);
    send_word(hdr);
    if (!chain) begin
      idle(gap);
      send_word(a);
    end
    idle(gap);
    send_word(b);
    check("exec_out_valid", bus.out_valid, 0);
    check("exec_in_ready", bus.in_ready, 0);
    check("exec_busy", busy, 1);
    check("alu_op", bus.alu_op, op);
    check("alu_a", bus.alu_a, ea);
    check("alu_b", bus.alu_b, b);
    @(negedge clk);
    check("res_out_valid", bus.out_valid, 1);
    check("res_out_data", bus.out_data, er);
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'($urandom);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_out_data", bus.out_data, er);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_op_count", op_count, m_count % (1 << CW));
        check("stall_alu_b", bus.alu_b, b);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    m_count++;
    m_acc = er;
    @(negedge clk);
    check("op_count", op_count, m_count % (1 << CW));
    check("post_out_valid", bus.out_valid, 0);
    check("post_busy", busy, 0);
    check("post_in_ready", bus.in_ready, 1);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_out_data", bus.out_data, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_acc   = '0;
    m_count = 0;
    check("rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("init_in_ready", bus.in_ready, 1);
    check("init_busy", busy, 0);
    check("init_out_valid", bus.out_valid, 0);
    check("init_op_count", op_count, 0);
    check("init_alu_op", bus.alu_op, 0);
    check("init_alu_a", bus.alu_a, 0);
    check("init_alu_b", bus.alu_b, 0);
    check("init_out_data", bus.out_data, 0);

    run_cmd(2'd0, 1'b0, 16'd2, 16'd3, 0, 0);
    run_cmd(2'd1, 1'b0, 16'd100, 16'd200, 0, 1);
    run_cmd(2'd3, 1'b0, 16'd10, 16'd3, 0, 0);
    run_cmd(2'd0, 1'b0, 16'd2, 16'd3, 0, 0);
    run_cmd(2'd0, 1'b1, 16'd0, 16'd10, 0, 0);

    pulse_reset();
    run_cmd(2'd0, 1'b1, 16'd0, 16'd7, 0, 0);
    run_cmd(2'd0, 1'b0, 16'($urandom), 16'($urandom), 3, 0);

    send_word({13'd0, 1'b0, 2'd1});
    send_word(16'h1234);
    pulse_reset();
    check("mid_rst_alu_op", bus.alu_op, 0);
    run_cmd(2'd1, 1'b0, 16'h0050, 16'h0010, 0, 0);

    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      run_cmd(2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 0, 0);
    end

    for (int i = 0; i < 80; i++) begin
      run_cmd(2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
